// File: rtl/cnn_fmap_sched_pkg.sv
// cnn_fmap_sched_pkg: scheduler state encoding and fmap geometry helpers.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package cnn_fmap_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_e;

  // Output fmap side length for an unpadded, stride-1 convolution.
  function automatic int calc_ox(input int ix, input int kx);
    return ix - kx + 1;
  endfunction

  // Pixels per square input fmap.
  function automatic int calc_npix(input int ix);
    return ix * ix;
  endfunction

endpackage

// File: rtl/cnn_fmap_sched_if.sv
// cnn_fmap_sched_if: control, image RAM read port and conv-core stream of the scheduler.
// Latency: n/a (wiring only); RAM data is expected 1 cycle after o_mem_rd_en.
// Backpressure: i_stall from the consumer side pauses reads.
// Ports: master = scheduler side, slave = environment side (control, RAM, conv core).
// Optional: o_err exists only when CNN_SCHED_ERR_EN is defined.
interface cnn_fmap_sched_if #(
  parameter int I_F_BW  = 8,
  parameter int ADDR_BW = 10
);
  logic               i_start;
  logic               i_stall;
  logic               o_busy;
  logic               o_done;
  logic               o_mem_rd_en;
  logic [ADDR_BW-1:0] o_mem_addr;
  logic [I_F_BW-1:0]  i_mem_rd_data;
  logic               o_core_valid;
  logic [I_F_BW-1:0]  o_core_fmap;
  logic               i_core_ot_valid;
  logic [ADDR_BW-1:0] o_ot_cnt;
`ifdef CNN_SCHED_ERR_EN
  logic               o_err;
`endif

  modport master (
    input  i_start, i_stall, i_mem_rd_data, i_core_ot_valid,
    output o_busy, o_done, o_mem_rd_en, o_mem_addr, o_core_valid, o_core_fmap, o_ot_cnt
`ifdef CNN_SCHED_ERR_EN
    , output o_err
`endif
  );

  modport slave (
    output i_start, i_stall, i_mem_rd_data, i_core_ot_valid,
    input  o_busy, o_done, o_mem_rd_en, o_mem_addr, o_core_valid, o_core_fmap, o_ot_cnt
`ifdef CNN_SCHED_ERR_EN
    , input o_err
`endif
  );

endinterface

// File: rtl/cnn_fmap_sched.sv
// cnn_fmap_sched: streams an IX*IX fmap from image RAM to the conv core in raster order.
// Latency: read strobe follows state combinationally; pixel reaches the core 1 cycle after its read.
// Backpressure: i_stall pauses reads (an in-flight read still lands); done waits for all OX*OX core outputs.
// Ports: clk; reset (async, active-high); bus (cnn_fmap_sched_if.master): start/stall, busy/done,
//   RAM read port, core pixel stream, core output count.
// Optional: define CNN_SCHED_ERR_EN to add the WDOG drain watchdog and the sticky o_err flag.
module cnn_fmap_sched
  import cnn_fmap_sched_pkg::*;
#(
  parameter int IX      = 28,
  parameter int KX      = 5,
  parameter int I_F_BW  = 8,
  parameter int ADDR_BW = 10
`ifdef CNN_SCHED_ERR_EN
  ,
  parameter int WDOG    = 4096
`endif
) (
  input logic              clk,
  input logic              reset,
  cnn_fmap_sched_if.master bus
);

  localparam int OX   = calc_ox(IX, KX);
  localparam int NPIX = calc_npix(IX);
  localparam logic [ADDR_BW-1:0] LAST_ADDR = ADDR_BW'(NPIX - 1);
  localparam logic [ADDR_BW-1:0] OUT_TOTAL = ADDR_BW'(OX * OX);

  sched_state_e       state_q, state_d;
  logic [ADDR_BW-1:0] addr_q;
  logic [ADDR_BW-1:0] cnt_q;
  logic               core_vld_q;
  logic               start_ok;
  logic               rd_en;
  logic               cnt_full;
  logic               ot_accept;

  assign start_ok  = (state_q == ST_IDLE) && bus.i_start;
  assign rd_en     = (state_q == ST_FETCH) && !bus.i_stall;
  assign cnt_full  = (cnt_q == OUT_TOTAL);
  // Core outputs count in FETCH, DRAIN and DONE; the counter saturates.
  assign ot_accept = bus.i_core_ot_valid && (state_q != ST_IDLE) && !cnt_full;

`ifdef CNN_SCHED_ERR_EN
  localparam int WD_BW = $clog2(WDOG + 1);

  logic [WD_BW-1:0] wd_q;
  logic             err_q;
  logic             wd_hit;
  logic             err_set;

  // wd_q counts DRAIN cycles already spent, so a hit marks the WDOG-th one.
  assign wd_hit  = (state_q == ST_DRAIN) && (wd_q == WD_BW'(WDOG - 1));
  assign err_set = wd_hit || (bus.i_core_ot_valid && ((state_q == ST_IDLE) || cnt_full));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q <= (state_q == ST_DRAIN) ? wd_q + WD_BW'(1) : '0;
      if (start_ok) begin
        err_q <= 1'b0;
      end else if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.o_err = err_q;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (rd_en && (addr_q == LAST_ADDR)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
`ifdef CNN_SCHED_ERR_EN
        if (cnt_full || wd_hit) state_d = ST_DONE;
`else
        if (cnt_full) state_d = ST_DONE;
`endif
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      core_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      core_vld_q <= rd_en;
      if (start_ok) begin
        addr_q <= '0;
      end else if (rd_en) begin
        addr_q <= addr_q + ADDR_BW'(1);
      end
      if (start_ok) begin
        cnt_q <= '0;
      end else if (ot_accept) begin
        cnt_q <= cnt_q + ADDR_BW'(1);
      end
    end
  end

  assign bus.o_busy       = (state_q != ST_IDLE);
  assign bus.o_done       = (state_q == ST_DONE);
  assign bus.o_mem_rd_en  = rd_en;
  assign bus.o_mem_addr   = addr_q;
  assign bus.o_core_valid = core_vld_q;
  // The RAM registers its read data, so the word on i_mem_rd_data in the
  // cycle after the strobe lines up with core_vld_q without another flop.
  assign bus.o_core_fmap  = core_vld_q ? bus.i_mem_rd_data : {I_F_BW{1'b0}};
  assign bus.o_ot_cnt     = cnt_q;

endmodule

// File: doc/cnn_fmap_sched.md
CNN_FMAP_SCHED -- requirements
Module: cnn_fmap_sched

Interface
REQ-001 Parameter IX, default 28: input fmap width and height, in pixels.
REQ-002 Parameter KX, default 5: kernel width and height.
REQ-003 Parameter I_F_BW, default 8: pixel bit width.
REQ-004 Parameter ADDR_BW, default 10: image RAM address width; SHALL satisfy 2^ADDR_BW >= IX*IX.
REQ-005 Parameter WDOG, default 4096: drain watchdog limit in cycles (used only under CNN_SCHED_ERR_EN).
REQ-006 Port clk, input, 1: single clock; all logic on rising edge.
REQ-007 Port reset, input, 1: asynchronous, active-high reset.
REQ-008 Port i_start, input, 1: one-cycle frame start request.
REQ-009 Port i_stall, input, 1: pause fetch while high.
REQ-010 Port o_busy, output, 1: high in any state other than IDLE.
REQ-011 Port o_done, output, 1: one-cycle frame-complete pulse.
REQ-012 Port o_mem_rd_en, output, 1: image RAM read strobe.
REQ-013 Port o_mem_addr, output, ADDR_BW: image RAM read address, raster order.
REQ-014 Port i_mem_rd_data, input, I_F_BW: RAM data; valid exactly 1 cycle after o_mem_rd_en.
REQ-015 Port o_core_valid, output, 1: pixel-valid to the conv core.
REQ-016 Port o_core_fmap, output, I_F_BW: pixel to the conv core.
REQ-017 Port i_core_ot_valid, input, 1: conv core output-valid strobe.
REQ-018 Port o_ot_cnt, output, ADDR_BW: count of core outputs received this frame.
REQ-019 Port o_err, output, 1: sticky error flag; present only under CNN_SCHED_ERR_EN.

Function
REQ-020 The FSM SHALL have four states: IDLE, FETCH, DRAIN and DONE.
REQ-021 IDLE SHALL go to FETCH on i_start; it SHALL also clear the address counter and o_ot_cnt on that transition.
REQ-022 i_start SHALL be ignored in every state other than IDLE.
REQ-023 In FETCH, each cycle with i_stall=0 SHALL assert o_mem_rd_en with the current o_mem_addr, then increment the address.
REQ-024 In FETCH, each cycle with i_stall=1 SHALL hold o_mem_rd_en=0 and hold the address.
REQ-025 o_core_valid SHALL be o_mem_rd_en delayed by 1 cycle, and o_core_fmap SHALL equal i_mem_rd_data registered in that same cycle.
REQ-026 When i_stall rises, a read already issued SHALL still be delivered to the core.
REQ-027 FETCH SHALL go to DRAIN in the cycle after the read of address IX*IX-1 is issued; exactly IX*IX reads SHALL be issued per frame.
REQ-028 o_ot_cnt SHALL increment on each i_core_ot_valid while busy, saturating at OX*OX, where OX = IX-KX+1.
REQ-029 DRAIN SHALL go to DONE once o_ot_cnt = OX*OX, including when that count is reached while still in FETCH.
REQ-030 DONE SHALL last 1 cycle with o_done=1, then return to IDLE; o_ot_cnt SHALL hold its value until the next start.
REQ-031 i_stall SHALL have no effect in DRAIN, DONE or IDLE.

Reset
REQ-032 While reset is high, the block SHALL force IDLE with address=0, o_ot_cnt=0 and all outputs 0.
REQ-033 Reset asserted mid-frame SHALL abort the frame immediately and SHALL NOT produce an o_done pulse.

Configuration
REQ-034 With CNN_SCHED_ERR_EN defined, a DRAIN cycle counter SHALL be present; on reaching WDOG cycles it SHALL set o_err and force DONE.
REQ-035 With CNN_SCHED_ERR_EN defined, i_core_ot_valid received in IDLE or after saturation SHALL also set o_err.
REQ-036 o_err SHALL be cleared only by reset or by an accepted i_start.
REQ-037 Without CNN_SCHED_ERR_EN, the o_err port, the watchdog and the error logic SHALL be absent, and DRAIN SHALL wait indefinitely.

Structure
REQ-038 A shared package SHALL hold the state encoding (IDLE=0, FETCH=1, DRAIN=2, DONE=3) and the OX and IX*IX helper constants.
REQ-039 The block SHALL be a single module with no sub-module; the FSM, address counter, output counter and watchdog are all inline.

Verification
REQ-040 IX=28, KX=5, start with no stall -> addresses 0..783 issued on consecutive cycles; core valid trails each read by 1 cycle; o_done after the 576th i_core_ot_valid; o_ot_cnt=576.
REQ-041 Stall high for 3 cycles at address 100 -> no reads during the stall; read 99 still delivered; resumes at address 100; total reads still 784.
REQ-042 i_start pulsed during FETCH and again during DRAIN -> no restart; address sequence unchanged.
REQ-043 Reset asserted at address 400 -> all outputs 0 immediately, no o_done; a new start then begins at address 0.
REQ-044 ERR_EN defined, WDOG=50, only 575 outputs supplied -> o_err=1 after 50 DRAIN cycles, o_done pulses, o_err clears on next start.
REQ-045 ERR_EN defined, i_core_ot_valid pulsed in IDLE -> o_err=1 and o_ot_cnt unchanged.
